// File: rtl/fifo_rd_packer.sv
// Read-side consumer of the async FIFO, running in the FIFO read-clock domain.
// Pops WIDTH-bit words whenever the FIFO has data. Packs PACK of them into one
// wide word, lane 0 first, and presents that word on a valid/ready stream.
// A partial word is emitted on an explicit flush, or after TIMEOUT idle cycles.
//
// Ports
//   clk_i            read-domain clock (same clock as the FIFO read side)
//   rst_n_i          synchronous, active-low reset
//   fifo_empty_i     FIFO empty flag
//   fifo_rdata_i     FIFO read data, valid one cycle after a pop
//   fifo_rd_error_i  FIFO read-error flag
//   fifo_rd_en_o     FIFO pop request (combinational)
//   flush_i          one-cycle pulse: emit the current partial word
//   m_data_o         packed word; lane k = bits [k*WIDTH +: WIDTH]
//   m_keep_o         lane-valid mask, LSB = lane 0
//   m_valid_o        output word valid
//   m_ready_i        downstream accept
//   rd_err_cnt_o     saturating count of cycles with fifo_rd_error_i set
module fifo_rd_packer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PACK    = 2,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    fifo_empty_i,
    input  logic [WIDTH-1:0]        fifo_rdata_i,
    input  logic                    fifo_rd_error_i,
    output logic                    fifo_rd_en_o,
    input  logic                    flush_i,
    output logic [WIDTH*PACK-1:0]   m_data_o,
    output logic [PACK-1:0]         m_keep_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [CNT_W-1:0]        rd_err_cnt_o
);

    localparam int unsigned OUT_W  = WIDTH * PACK;
    localparam int unsigned LANE_W = $clog2(PACK + 1);
    localparam int unsigned SUM_W  = LANE_W + 1;
    // Holds TIMEOUT+1: the counter may tick once more on the cycle it hits TIMEOUT.
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 2);

    // Registered state
    logic [LANE_W-1:0] lane_cnt;
    logic              inflight;
    logic              flush_pend;
    logic [IDLE_W-1:0] idle_cnt;
    logic [OUT_W-1:0]  acc;

    // Next-state values
    logic [LANE_W-1:0] lane_cnt_n;
    logic              flush_pend_n;
    logic [IDLE_W-1:0] idle_cnt_n;
    logic [OUT_W-1:0]  acc_n;
    logic [OUT_W-1:0]  m_data_n;
    logic [PACK-1:0]   m_keep_n;
    logic              m_valid_n;
    logic [CNT_W-1:0]  err_cnt_n;

    // Decoded conditions
    logic room;
    logic capture;
    logic out_free;
    logic load_full;
    logic load_part;
    logic load;
    logic flush_empty;
    logic idle_tick;
    logic timeout_hit;

    // Lanes already captured plus the one in flight must leave space for another pop.
    assign room = (SUM_W'(lane_cnt) + SUM_W'(inflight)) < SUM_W'(PACK);

    assign fifo_rd_en_o = rst_n_i & ~fifo_empty_i & ~flush_pend & room;

    assign capture     = inflight;
    assign out_free    = ~m_valid_o | m_ready_i;
    assign load_full   = (lane_cnt == LANE_W'(PACK));
    assign load_part   = flush_pend & ~inflight & (lane_cnt != '0);
    assign load        = (load_full | load_part) & out_free;
    assign flush_empty = flush_pend & ~inflight & (lane_cnt == '0) & out_free;

    // The accumulator has been sitting with nothing arriving and no flush requested.
    assign idle_tick   = (TIMEOUT != 0) & (lane_cnt != '0) & ~inflight
                       & ~fifo_rd_en_o & ~flush_pend;
    assign timeout_hit = (TIMEOUT != 0) & (idle_cnt == IDLE_W'(TIMEOUT));

    // Next-state logic for packing, output stream, flush and error count
    always_comb begin
        lane_cnt_n   = lane_cnt;
        flush_pend_n = flush_pend;
        idle_cnt_n   = idle_cnt;
        acc_n        = acc;
        m_data_n     = m_data_o;
        m_keep_n     = m_keep_o;
        m_valid_n    = m_valid_o;
        err_cnt_n    = rd_err_cnt_o;

        if (m_valid_o && m_ready_i) begin
            m_valid_n = 1'b0;
        end

        if (idle_tick) begin
            idle_cnt_n = idle_cnt + IDLE_W'(1);
        end

        // Capture and load never coincide: a full word implies no pop in flight.
        if (capture) begin
            for (int k = 0; k < PACK; k++) begin
                if (lane_cnt == LANE_W'(k)) begin
                    acc_n[k*WIDTH +: WIDTH] = fifo_rdata_i;
                end
            end
            lane_cnt_n = lane_cnt + LANE_W'(1);
            idle_cnt_n = '0;
        end

        // Unfilled lanes of acc are already zero, so acc goes out as-is.
        if (load) begin
            m_data_n = acc;
            for (int k = 0; k < PACK; k++) begin
                m_keep_n[k] = (LANE_W'(k) < lane_cnt);
            end
            m_valid_n  = 1'b1;
            lane_cnt_n = '0;
            acc_n      = '0;
            idle_cnt_n = '0;
        end

        // A pending flush absorbs further flush requests until it is served.
        if (flush_pend) begin
            if (load || flush_empty) begin
                flush_pend_n = 1'b0;
            end
        end else if (flush_i || timeout_hit) begin
            flush_pend_n = 1'b1;
        end

        if (fifo_rd_error_i && (rd_err_cnt_o != '1)) begin
            err_cnt_n = rd_err_cnt_o + CNT_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lane_cnt     <= '0;
            inflight     <= 1'b0;
            flush_pend   <= 1'b0;
            idle_cnt     <= '0;
            acc          <= '0;
            m_data_o     <= '0;
            m_keep_o     <= '0;
            m_valid_o    <= 1'b0;
            rd_err_cnt_o <= '0;
        end else begin
            lane_cnt     <= lane_cnt_n;
            inflight     <= fifo_rd_en_o;
            flush_pend   <= flush_pend_n;
            idle_cnt     <= idle_cnt_n;
            acc          <= acc_n;
            m_data_o     <= m_data_n;
            m_keep_o     <= m_keep_n;
            m_valid_o    <= m_valid_n;
            rd_err_cnt_o <= err_cnt_n;
        end
    end

endmodule
